// File: rtl/vga_game_pkg.sv
// Shared types for the VGA game HUD blocks: timer FSM states and two-digit BCD values.
package vga_game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam int BCD_MAX = 99;

  function automatic int bcd2_to_int(bcd2_t v);
    return int'(v.tens) * 10 + int'(v.ones);
  endfunction

endpackage

// File: rtl/bcd2_addsub.sv
// Combinational two-digit BCD unit: decrement by one, and saturating add of ADD
// (also ADD-1, used when a tick and a bonus land in the same cycle).
module bcd2_addsub
  import vga_game_pkg::*;
#(
  parameter int ADD = 5
) (
  input  bcd2_t a,
  output bcd2_t minus1,
  output bcd2_t plus_k,
  output bcd2_t plus_k_minus1
);

  function automatic bcd2_t bcd_dec(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones != 4'd0) begin
      r.ones = v.ones - 4'd1;
    end else if (v.tens != 4'd0) begin
      r.tens = v.tens - 4'd1;
      r.ones = 4'd9;
    end
    return r;
  endfunction

  // Digit-wise add with decimal carry; any tens overflow clamps to BCD_MAX.
  function automatic bcd2_t bcd_add_sat(bcd2_t v, int k);
    logic [4:0] o;
    logic [4:0] t;
    bcd2_t      r;
    o = {1'b0, v.ones} + 5'(k % 10);
    t = {1'b0, v.tens} + 5'(k / 10);
    if (o > 5'd9) begin
      o = o - 5'd10;
      t = t + 5'd1;
    end
    if (t > 5'd9) begin
      r.tens = 4'(BCD_MAX / 10);
      r.ones = 4'(BCD_MAX % 10);
    end else begin
      r.tens = t[3:0];
      r.ones = o[3:0];
    end
    return r;
  endfunction

  assign minus1        = bcd_dec(a);
  assign plus_k        = bcd_add_sat(a, ADD);
  assign plus_k_minus1 = bcd_add_sat(a, ADD - 1);

endmodule

// File: rtl/game_countdown_timer.sv
// Two-digit BCD countdown for the game HUD: load/start/pause/bonus control,
// warning window and expiry flags; every output is registered (one cycle latency).
module game_countdown_timer
  import vga_game_pkg::*;
#(
  parameter int START_SEC = 60,
  parameter int WARN_SEC  = 10,
  parameter int BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       warning,
  output logic       expired,
  output logic       timeout
);

  localparam bcd2_t START_BCD = {4'(START_SEC / 10), 4'(START_SEC % 10)};

  timer_state_t state, state_nx;
  bcd2_t        cnt, cnt_nx;
  bcd2_t        cnt_dec, cnt_add, cnt_add_dec;
  logic         warn_nx;
  logic         at_last_sec;

  bcd2_addsub #(.ADD(BONUS_SEC)) u_addsub (
    .a             (cnt),
    .minus1        (cnt_dec),
    .plus_k        (cnt_add),
    .plus_k_minus1 (cnt_add_dec)
  );

  assign at_last_sec = (cnt.tens == 4'd0) && (cnt.ones <= 4'd1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (load) begin
      state_nx = IDLE;
      cnt_nx   = START_BCD;
    end else begin
      unique case (state)
        IDLE, PAUSED: begin
          // A start strobe consumes the cycle; ticks never count outside RUN.
          if (start)      state_nx = RUN;
          else if (bonus) cnt_nx   = cnt_add;
        end
        RUN: begin
          if (pause) begin
            state_nx = PAUSED;
          end else if (tick && bonus) begin
            cnt_nx = cnt_add_dec;
          end else if (tick) begin
            cnt_nx = cnt_dec;
            if (at_last_sec) state_nx = EXPIRED;
          end else if (bonus) begin
            cnt_nx = cnt_add;
          end
        end
        EXPIRED: begin
          cnt_nx = '0;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
    warn_nx = ((state_nx == RUN) || (state_nx == PAUSED)) &&
              (bcd2_to_int(cnt_nx) >= 1) && (bcd2_to_int(cnt_nx) <= WARN_SEC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      running <= 1'b0;
      warning <= 1'b0;
      expired <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      running <= (state_nx == RUN);
      warning <= warn_nx;
      expired <= (state_nx == EXPIRED);
      timeout <= (state_nx == EXPIRED) && (state != EXPIRED);
    end
  end

  assign tens = cnt.tens;
  assign ones = cnt.ones;

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Consumes the single-cycle seconds strobe produced by the board's slow-clock tick generator and turns it into a two-digit BCD countdown for the VGA game HUD. It is loaded with a start value, counts down one per strobe while running, supports pause and bonus-time credit, and flags the warning window and expiry to the game controller and the score/timer display.

## Interface
- START_SEC, 60: value loaded on `load`; legal range 1..99.
- WARN_SEC, 10: `warning` asserts while remaining seconds are in 1..WARN_SEC; legal range 0..START_SEC.
- BONUS_SEC, 5: seconds added per `bonus` strobe; legal range 1..99.

- clk  in  1  system clock, the same clock that drives the tick generator.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle seconds strobe. The timer never assumes a minimum spacing between strobes; turbo mode gives ten strobes per second.
- load  in  1  one-cycle strobe that loads START_SEC and enters IDLE.
- start  in  1  one-cycle strobe: IDLE or PAUSED goes to RUN.
- pause  in  1  one-cycle strobe: RUN goes to PAUSED.
- bonus  in  1  one-cycle strobe that adds BONUS_SEC, saturating at 99.
- tens  out  4  BCD tens digit of the remaining seconds (0..9).
- ones  out  4  BCD ones digit of the remaining seconds (0..9).
- running  out  1  high in RUN.
- warning  out  1  high when in RUN or PAUSED and remaining is in 1..WARN_SEC.
- expired  out  1  high in EXPIRED.
- timeout  out  1  one-cycle pulse on entry to EXPIRED.

## Operation
- **Counter state:** remaining seconds are held directly as two BCD digits, not as binary.
- **IDLE:**
  - `start` goes to RUN.
  - `tick` is ignored.
  - `pause` is ignored.
- **RUN:**
  - `tick` decrements the count.
    - From N0 (ones = 0, N > 0) the next value is (N-1)9.
    - From 01 the next value is 00 and the state goes to EXPIRED.
  - `pause` goes to PAUSED.
  - `start` is ignored.
- **PAUSED:**
  - `tick` is ignored.
  - `start` goes to RUN.
  - `pause` is ignored.
- **EXPIRED:**
  - The count holds at 00.
  - Only `load` or `reset` leaves this state.
  - `bonus` is ignored here; time cannot be revived after expiry.
- **`bonus`:** accepted in IDLE, RUN and PAUSED. It performs a BCD add of BONUS_SEC and saturates at 99.
- **Priority within one cycle:** `load` > `pause` > `start` > (`tick`, `bonus`).
- **`tick` and `bonus` in the same cycle while in RUN:**
  - The net change is +BONUS_SEC-1.
  - If the count was 01, the timer does not expire; the result is BONUS_SEC.
- **`load` in any state,** including mid-RUN or EXPIRED:
  - The count becomes START_SEC and the state becomes IDLE.
  - Any `tick` or `bonus` in the same cycle is ignored.
- **`start` and `tick` in the same cycle from IDLE or PAUSED:** the tick is not counted.
- **`pause` and `tick` in the same cycle in RUN:** the tick is not counted; `pause` wins.

## Timing
- **Registers and latency:** all outputs are registered. Every count or state change is visible on the clock edge that samples the causing strobe, i.e. one cycle of latency.
- **`timeout`:** high for exactly the one cycle in which `expired` first reads 1.
- **`warning`:** derived from the registered count and state. It changes in the same cycle as the digits.
- **Reset values:**
  - `tens` = 0, `ones` = 0.
  - State is IDLE, so `running` = 0, `warning` = 0, `expired` = 0, `timeout` = 0.
  - After reset, `load` is required to arm the timer.
- **Reset assertion mid-operation:** the timer returns to the reset values immediately (asynchronously), with no `timeout` pulse.
- **Back-to-back strobes:** `tick` on consecutive cycles is legal; each one decrements once.

## Structure
- **Shared package** (`vga_game_pkg`):
  - the state enum `timer_state_t` {IDLE, RUN, PAUSED, EXPIRED};
  - the typedef `bcd2_t` (struct of two 4-bit digits);
  - the constant `BCD_MAX` = 99.
- **Sub-module** `bcd2_addsub`: a combinational two-digit BCD unit providing decrement-by-1 and saturating add-by-constant. It is instantiated once and is unit-testable on its own.
- **Top level:** the FSM plus the count register.

## Test plan
- **Basic countdown:** reset, `load`, `start`, 61 `tick`s with START_SEC=60.
  - Count goes 60, 59, …, 01, 00.
  - `warning` is high from 10 down to 01.
  - `timeout` pulses once, in the cycle `expired` first reads 1.
  - The 61st tick causes no change.
- **Borrow:** count at 40 in RUN, one `tick` -> 39. Count at 10, one `tick` -> 09.
- **Pause:** RUN at 25, `pause`, 5 `tick`s -> holds at 25 with `warning` = 0. Then `start`, `tick` -> 24.
- **Bonus in RUN:**
  - At 01, simultaneous `tick` + `bonus` (BONUS_SEC=5) -> 05, no expiry.
  - At 97, `bonus` -> 99 (saturated).
  - In EXPIRED, `bonus` -> stays at 00.
- **Priority:**
  - RUN at 30, `load` + `tick` + `pause` in the same cycle -> 60 and IDLE.
  - IDLE, `start` + `tick` -> 60 and RUN.
- **Asynchronous reset:** assert `reset` mid-RUN between clock edges -> outputs go to reset values immediately, and no `timeout` pulse follows.
